cmd_assembler: RTL and testbench
================================

# cmd_assembler

Upstream front end of the uTPU controller. Pops bytes from the receive FIFO and assembles 16-bit instruction words, least-significant byte first. Fetches any extension words the opcode requires and presents one complete decoded command to the controller FSM over a valid/ready handshake. Consumes NOPs, rejects illegal opcodes, recovers from truncated byte streams by timeout, and latches a halt.

## Interface

Parameters:
- FIFO_DATA_WIDTH, 8, receive FIFO byte width
- BUFFER_WORD_SIZE, 16, instruction/data word width (= 2 × FIFO_DATA_WIDTH)
- ADDRESS_SIZE, 9, unified-buffer address width
- OPCODE_WIDTH, 3, opcode field width
- TIMEOUT_CYCLES, 65535, consecutive empty cycles tolerated mid-command

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- fifo_empty  in  1  receive FIFO empty
- fifo_rdata  in  8  FIFO head byte, first-word-fall-through, valid whenever ~fifo_empty
- fifo_re  out  1  pop head byte at this edge
- cmd_valid  out  1  command presented
- cmd_ready  in  1  controller accepts command
- cmd_opcode  out  3  instruction[2:0]
- cmd_flags  out  5  instruction[7:3]
- cmd_address  out  9  target buffer address
- cmd_data  out  16  store data word, 0 when cmd_has_data=0
- cmd_has_data  out  1  cmd_data is meaningful (STORE only)
- err_opcode  out  1  one-cycle pulse: illegal opcode dropped
- timeout_err  out  1  one-cycle pulse: partial command discarded
- halted  out  1  HALT issued; parser frozen

## Operation

- Opcodes: STORE=0, FETCH=1, RUN=2, LOAD=3, HALT=4, NOP=5. Values 6 and 7 are illegal.
- States:
  - INSTR_LO: wait for the instruction low byte.
  - INSTR_HI: wait for the instruction high byte, then decode.
  - EXT_LO / EXT_HI: collect an extension word.
  - ISSUE: present the command.
  - HALTED: frozen after HALT.
- Byte pops happen only in INSTR_LO, INSTR_HI, EXT_LO and EXT_HI:
  - fifo_re = ~fifo_empty (combinational).
  - The byte is captured at the same edge.
- Decode at the INSTR_HI pop:
  - FETCH, RUN, LOAD, HALT → ISSUE, with cmd_address = instruction[15:7].
  - NOP → INSTR_LO. Nothing is issued and no flag is raised.
  - Illegal opcode → pulse err_opcode, return to INSTR_LO.
  - STORE with instruction[4]=0 → one extension word, the data. cmd_address = instruction[15:7].
  - STORE with instruction[4]=1 → two extension words: address (its bits [8:0]), then data.
- The extension word count is held in a 2-bit counter. The last EXT_HI pop moves to ISSUE.
- ISSUE:
  - cmd_valid is held high with all cmd_* outputs stable until cmd_valid & cmd_ready.
  - After the transfer edge the state is INSTR_LO, or HALTED if the opcode was HALT.
  - fifo_re=0 throughout ISSUE (no lookahead).
- HALTED: halted=1, fifo_re=0, cmd_valid=0 until rst.
- Timeout:
  - Applies in INSTR_HI, EXT_LO and EXT_HI.
  - A 16-bit counter increments on each empty cycle and clears on each pop.
  - When it reaches TIMEOUT_CYCLES: pulse timeout_err, clear the partial command, go to INSTR_LO.
  - The counter is idle in INSTR_LO and ISSUE.

## Timing

- Reset values: all outputs 0, state INSTR_LO, counters and assembled registers 0.
- Reset mid-command discards all partial bytes. Bytes already popped are lost.
- Latency: the final byte is popped at edge N, cmd_valid=1 in cycle N+1.
- Minimum throughput, with a continuously non-empty FIFO and cmd_ready tied high:
  - 3 cycles per plain command.
  - 5 cycles per STORE with one extension word.
  - 7 cycles per STORE with two extension words.
- err_opcode is asserted the cycle after the offending pop. timeout_err is asserted the cycle after the limit is reached.
- Outputs are registered except fifo_re.
- Simultaneous events:
  - A byte arriving on the timeout cycle: the timeout wins and the byte is not popped.
  - rst overrides everything.

## Structure

- The shared package utpu_pkg holds:
  - opcode_e
  - the cmd_assembler state enum
  - the cmd_t struct (opcode, flags, address, data, has_data), reused by the controller
- No sub-module. The timeout counter and byte assembly are inline.

## Test plan

- FETCH: bytes 0x09, 0x01 → one cycle after the second pop:
  - cmd_valid=1, opcode=1, flags=0x01, address=0x002, has_data=0.
- STORE, short form: 0x80, 0x00, 0xCD, 0xAB → opcode=0, address=0x001, data=0xABCD, has_data=1. cmd_valid rises only after the 4th pop.
- STORE, extended form: 0x10, 0x00, 0x34, 0x01, 0xEF, 0xBE → address=0x134, data=0xBEEF.
- Backpressure: FETCH with cmd_ready held low for 5 cycles and the FIFO non-empty:
  - fifo_re stays 0 and outputs stay stable.
  - Exactly one transfer occurs.
  - The next byte pops in the cycle after acceptance.
- Illegal and NOP, then a valid command: 0x07, 0x00 → err_opcode single pulse, no cmd_valid. 0x05, 0x00 → no response. A following 0x03, 0x00 issues LOAD.
- Timeout and halt:
  - With TIMEOUT_CYCLES=16, byte 0x01 then an empty FIFO → timeout_err on the cycle after the 16th empty cycle. The next bytes parse as a new instruction.
  - Bytes 0x04, 0x00 then more bytes → HALT issued, halted=1, fifo_re=0 until rst.

Source files
------------

// File: rtl/utpu_pkg.sv
// Purpose : shared types for the uTPU command path (opcodes, assembler states, command struct).
// Latency : n/a (package only).
// Backpr. : n/a (package only).
//
// cmd_t is the decoded command handed from cmd_assembler to the controller FSM.
package utpu_pkg;

    localparam int UTPU_BYTE_W = 8;                          // receive FIFO byte
    localparam int UTPU_WORD_W = 16;                         // instruction / data word
    localparam int UTPU_ADDR_W = 9;                          // unified-buffer address
    localparam int UTPU_OP_W   = 3;                          // opcode field
    localparam int UTPU_FLAG_W = UTPU_BYTE_W - UTPU_OP_W;    // instruction[7:3]

    typedef enum logic [UTPU_OP_W-1:0] {
        OP_STORE = 3'd0,
        OP_FETCH = 3'd1,
        OP_RUN   = 3'd2,
        OP_LOAD  = 3'd3,
        OP_HALT  = 3'd4,
        OP_NOP   = 3'd5
    } opcode_e;

    // Assembler state encoding, kept as plain constants so older tools and
    // waveform scripts that match on raw values keep working.
    typedef logic [2:0] asm_state_t;
    localparam asm_state_t ST_INSTR_LO = 3'd0;
    localparam asm_state_t ST_INSTR_HI = 3'd1;
    localparam asm_state_t ST_EXT_LO   = 3'd2;
    localparam asm_state_t ST_EXT_HI   = 3'd3;
    localparam asm_state_t ST_ISSUE    = 3'd4;
    localparam asm_state_t ST_HALTED   = 3'd5;

    typedef struct packed {
        logic [UTPU_OP_W-1:0]   opcode;
        logic [UTPU_FLAG_W-1:0] flags;
        logic [UTPU_ADDR_W-1:0] address;
        logic [UTPU_WORD_W-1:0] data;
        logic                   has_data;
    } cmd_t;

    // A STORE carries its data word, plus a leading address word when the
    // instruction's address-extension bit (instruction[4]) is set.
    function automatic logic [1:0] store_ext_words(input logic addr_ext);
        return addr_ext ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/cmd_assembler.sv
// Purpose : pops LSB-first bytes from the receive FIFO and presents decoded uTPU commands.
// Latency : cmd_valid rises the cycle after the command's final byte is popped.
// Backpr. : while cmd_valid & ~cmd_ready, cmd_* are held and no bytes are popped.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   fifo_empty         receive FIFO empty
//   fifo_rdata         FIFO head byte (first-word-fall-through)
//   fifo_re            pop head byte at this edge (combinational)
//   cmd_valid/ready    command handshake to the controller FSM
//   cmd_opcode/flags   instruction[2:0] / instruction[7:3]
//   cmd_address        target unified-buffer address
//   cmd_data/has_data  STORE data word and its qualifier
//   err_opcode         one-cycle pulse: illegal opcode dropped
//   timeout_err        one-cycle pulse: partial command discarded
//   halted             HALT issued, parser frozen until reset
module cmd_assembler
    import utpu_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH  = 8,
    parameter int BUFFER_WORD_SIZE = 16,
    parameter int ADDRESS_SIZE     = 9,
    parameter int OPCODE_WIDTH     = 3,
    parameter int TIMEOUT_CYCLES   = 65535
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  fifo_empty,
    input  logic [FIFO_DATA_WIDTH-1:0]            fifo_rdata,
    output logic                                  fifo_re,
    output logic                                  cmd_valid,
    input  logic                                  cmd_ready,
    output logic [OPCODE_WIDTH-1:0]               cmd_opcode,
    output logic [FIFO_DATA_WIDTH-OPCODE_WIDTH-1:0] cmd_flags,
    output logic [ADDRESS_SIZE-1:0]               cmd_address,
    output logic [BUFFER_WORD_SIZE-1:0]           cmd_data,
    output logic                                  cmd_has_data,
    output logic                                  err_opcode,
    output logic                                  timeout_err,
    output logic                                  halted
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] TIMEOUT_LAST  = 16'(TIMEOUT_CYCLES - 1);

    asm_state_t                 state_q;
    logic [UTPU_BYTE_W-1:0]     instr_lo_q;
    logic [UTPU_BYTE_W-1:0]     ext_lo_q;
    logic [1:0]                 ext_cnt_q;      // extension words still to collect
    logic [15:0]                idle_cnt_q;     // consecutive empty cycles mid-command
    cmd_t                       cmd_q;
    logic                       cmd_valid_q;
    logic                       halted_q;
    logic                       err_opcode_q;
    logic                       timeout_err_q;

    logic                       pop_state;
    logic                       wait_state;
    logic                       timeout_hit;
    logic [UTPU_WORD_W-1:0]     ext_word;
    cmd_t                       dec;

    // ------------------------------------------------------------------
    // Pop control
    // ------------------------------------------------------------------
    always_comb begin
        pop_state   = state_q inside {ST_INSTR_LO, ST_INSTR_HI, ST_EXT_LO, ST_EXT_HI};
        wait_state  = state_q inside {ST_INSTR_HI, ST_EXT_LO, ST_EXT_HI};
        // The timeout cycle owns the FIFO: a byte that shows up right then
        // stays in the FIFO and starts the next instruction.
        timeout_hit = wait_state && (idle_cnt_q == TIMEOUT_LIMIT);
        fifo_re     = !rst && pop_state && !fifo_empty && !timeout_hit;
    end

    // ------------------------------------------------------------------
    // Decode of the instruction word at the high-byte pop
    // ------------------------------------------------------------------
    always_comb begin
        dec          = '0;
        dec.opcode   = instr_lo_q[UTPU_OP_W-1:0];
        dec.flags    = instr_lo_q[UTPU_BYTE_W-1:UTPU_OP_W];
        // instruction[15:7] straddles the two bytes
        dec.address  = {fifo_rdata, instr_lo_q[UTPU_BYTE_W-1]};
        dec.has_data = (instr_lo_q[UTPU_OP_W-1:0] == OP_STORE);
        ext_word     = {fifo_rdata, ext_lo_q};
    end

    // ------------------------------------------------------------------
    // Timeout counter: only runs while a command is partially assembled
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            if (!wait_state || fifo_re || timeout_hit) begin
                idle_cnt_q <= '0;
            end else begin
                idle_cnt_q <= idle_cnt_q + 16'd1;
                // Flag goes out together with the limit being reached, so it
                // is visible during the cycle in which the discard happens.
                if (idle_cnt_q == TIMEOUT_LAST) begin
                    timeout_err_q <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte assembly / command FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INSTR_LO;
            instr_lo_q   <= '0;
            ext_lo_q     <= '0;
            ext_cnt_q    <= '0;
            cmd_q        <= '0;
            cmd_valid_q  <= 1'b0;
            halted_q     <= 1'b0;
            err_opcode_q <= 1'b0;
        end else begin
            err_opcode_q <= 1'b0;
            if (timeout_hit) begin
                instr_lo_q <= '0;
                ext_lo_q   <= '0;
                ext_cnt_q  <= '0;
                cmd_q      <= '0;
                state_q    <= ST_INSTR_LO;
            end else begin
                case (state_q)
                    ST_INSTR_LO: begin
                        if (fifo_re) begin
                            instr_lo_q <= fifo_rdata;
                            state_q    <= ST_INSTR_HI;
                        end
                    end

                    ST_INSTR_HI: begin
                        if (fifo_re) begin
                            case (instr_lo_q[UTPU_OP_W-1:0])
                                OP_FETCH, OP_RUN, OP_LOAD, OP_HALT: begin
                                    cmd_q       <= dec;
                                    cmd_valid_q <= 1'b1;
                                    state_q     <= ST_ISSUE;
                                end
                                OP_STORE: begin
                                    cmd_q     <= dec;
                                    ext_cnt_q <= store_ext_words(instr_lo_q[4]);
                                    state_q   <= ST_EXT_LO;
                                end
                                OP_NOP: begin
                                    state_q <= ST_INSTR_LO;
                                end
                                default: begin
                                    err_opcode_q <= 1'b1;
                                    state_q      <= ST_INSTR_LO;
                                end
                            endcase
                        end
                    end

                    ST_EXT_LO: begin
                        if (fifo_re) begin
                            ext_lo_q <= fifo_rdata;
                            state_q  <= ST_EXT_HI;
                        end
                    end

                    ST_EXT_HI: begin
                        if (fifo_re) begin
                            if (ext_cnt_q == 2'd2) begin
                                // Address extension word precedes the data word.
                                cmd_q.address <= ext_word[UTPU_ADDR_W-1:0];
                                ext_cnt_q     <= 2'd1;
                                state_q       <= ST_EXT_LO;
                            end else begin
                                cmd_q.data  <= ext_word;
                                ext_cnt_q   <= 2'd0;
                                cmd_valid_q <= 1'b1;
                                state_q     <= ST_ISSUE;
                            end
                        end
                    end

                    ST_ISSUE: begin
                        if (cmd_ready) begin
                            cmd_valid_q <= 1'b0;
                            if (cmd_q.opcode == OP_HALT) begin
                                halted_q <= 1'b1;
                                state_q  <= ST_HALTED;
                            end else begin
                                state_q <= ST_INSTR_LO;
                            end
                        end
                    end

                    ST_HALTED: begin
                        state_q <= ST_HALTED;
                    end

                    default: begin
                        state_q <= ST_INSTR_LO;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    assign cmd_valid    = cmd_valid_q;
    assign cmd_opcode   = cmd_q.opcode;
    assign cmd_flags    = cmd_q.flags;
    assign cmd_address  = cmd_q.address;
    assign cmd_data     = cmd_q.data;
    assign cmd_has_data = cmd_q.has_data;
    assign err_opcode   = err_opcode_q;
    assign timeout_err  = timeout_err_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_cmd_assembler.sv
// Purpose : self-checking bench for cmd_assembler (directed scenarios + randomized stream).
// Latency : n/a.
// Backpr. : bench drives cmd_ready both held low and randomly toggled.
module tb_cmd_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        fifo_re;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode;
    logic [4:0]  cmd_flags;
    logic [8:0]  cmd_address;
    logic [15:0] cmd_data;
    logic        cmd_has_data;
    logic        err_opcode;
    logic        timeout_err;
    logic        halted;

    cmd_assembler #(
        .FIFO_DATA_WIDTH (8),
        .BUFFER_WORD_SIZE(16),
        .ADDRESS_SIZE    (9),
        .OPCODE_WIDTH    (3),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_rdata  (fifo_rdata),
        .fifo_re     (fifo_re),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_flags   (cmd_flags),
        .cmd_address (cmd_address),
        .cmd_data    (cmd_data),
        .cmd_has_data(cmd_has_data),
        .err_opcode  (err_opcode),
        .timeout_err (timeout_err),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Expected commands packed as {opcode, flags, address, data, has_data}.
    localparam logic [33:0] CMD_FETCH = {3'd1, 5'h01, 9'h002, 16'h0000, 1'b0};
    localparam logic [33:0] CMD_STS   = {3'd0, 5'h10, 9'h001, 16'hABCD, 1'b1};
    localparam logic [33:0] CMD_STX   = {3'd0, 5'h02, 9'h134, 16'hBEEF, 1'b1};
    localparam logic [33:0] CMD_LOAD0 = {3'd3, 5'h00, 9'h000, 16'h0000, 1'b0};
    localparam logic [33:0] CMD_LOAD1 = {3'd3, 5'h01, 9'h000, 16'h0000, 1'b0};
    localparam logic [33:0] CMD_HALT  = {3'd4, 5'h00, 9'h000, 16'h0000, 1'b0};

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  fq[$];        // bytes currently in the receive FIFO
    logic [7:0]  stim[$];
    logic [33:0] exp_q[$];
    logic [33:0] got[$];
    int          exp_err;
    bit          fifo_block = 1'b0;
    bit          ready_drv  = 1'b0;
    int          cyc = 0;
    int          pop_total = 0;

    // Values sampled in the middle of the most recent cycle.
    logic        s_re, s_valid, s_rdy, s_err, s_to, s_halt;
    logic [33:0] s_cmd;
    int          s_cyc;

    // One clock cycle: drive inputs, sample mid-cycle, then model the FIFO pop.
    task automatic cycle();
        fifo_empty = fifo_block || (fq.size() == 0);
        fifo_rdata = (fq.size() != 0) ? fq[0] : 8'($urandom);
        cmd_ready  = ready_drv;
        #1;
        s_re    = fifo_re;
        s_valid = cmd_valid;
        s_rdy   = ready_drv;
        s_err   = err_opcode;
        s_to    = timeout_err;
        s_halt  = halted;
        s_cmd   = {cmd_opcode, cmd_flags, cmd_address, cmd_data, cmd_has_data};
        s_cyc   = cyc;
        @(posedge clk);
        #1;
        if (s_re && fq.size() != 0) begin
            void'(fq.pop_front());
            pop_total++;
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fq.delete();
        fifo_block = 1'b0;
        ready_drv  = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
    endtask

    task automatic run_until_valid(input int budget, output int last_pop, output int first_valid);
        last_pop    = -1;
        first_valid = -1;
        for (int k = 0; k < budget; k++) begin
            cycle();
            if (s_re) last_pop = s_cyc;
            if (s_valid) begin
                first_valid = s_cyc;
                break;
            end
        end
    endtask

    task automatic accept();
        ready_drv = 1'b1;
        cycle();
        ready_drv = 1'b0;
    endtask

    // Reference model: walks the byte stream word by word and lists what the
    // controller should receive, plus how many illegal opcodes are dropped.
    task automatic model_stream();
        int          i;
        logic [15:0] w;
        logic [8:0]  a;
        logic [15:0] d;
        exp_q.delete();
        exp_err = 0;
        i = 0;
        while (i + 1 < stim.size()) begin
            w = {stim[i+1], stim[i]};
            i += 2;
            case (w[2:0])
                3'd0: begin
                    if (w[4]) begin
                        a = {stim[i+1][0], stim[i]};
                        d = {stim[i+3], stim[i+2]};
                        i += 4;
                    end else begin
                        a = w[15:7];
                        d = {stim[i+1], stim[i]};
                        i += 2;
                    end
                    exp_q.push_back({3'd0, w[7:3], a, d, 1'b1});
                end
                3'd1, 3'd2, 3'd3, 3'd4: exp_q.push_back({w[2:0], w[7:3], w[15:7], 16'h0000, 1'b0});
                3'd5: ;
                default: exp_err++;
            endcase
        end
    endtask

    task automatic test_reset();
        int lp, fv, p0;
        do_reset();
        cycle();
        n_checks++;
        if ({s_valid, s_re, s_err, s_to, s_halt} !== 5'b0 || s_cmd !== 34'h0)
            $display("FAIL reset_outputs: ctl=%b cmd=%h, need all zero", {s_valid, s_re, s_err, s_to, s_halt}, s_cmd);
        else n_pass++;
        // Reset in the middle of a STORE discards the partial bytes.
        fq = '{8'h80, 8'h00, 8'hCD};
        p0 = pop_total;
        for (int k = 0; k < 6 && fq.size() != 0; k++) cycle();
        n_checks++;
        if (pop_total - p0 !== 3) $display("FAIL reset_partial_pops: got %0d pops, need 3", pop_total - p0);
        else n_pass++;
        do_reset();
        fq = '{8'h09, 8'h01};
        run_until_valid(20, lp, fv);
        n_checks++;
        if (fv < 0 || s_cmd !== CMD_FETCH) $display("FAIL reset_midcmd: valid_cyc=%0d cmd=%h need %h", fv, s_cmd, CMD_FETCH);
        else n_pass++;
        accept();
    endtask

    task automatic test_fetch();
        int lp, fv;
        fq = '{8'h09, 8'h01};
        run_until_valid(20, lp, fv);
        n_checks++;
        if (fv < 0 || fv !== lp + 1) $display("FAIL fetch_latency: valid cycle %0d, last pop %0d, need pop+1", fv, lp);
        else n_pass++;
        n_checks++;
        if (s_cmd !== CMD_FETCH) $display("FAIL fetch_fields: got %h need %h", s_cmd, CMD_FETCH);
        else n_pass++;
        accept();
        cycle();
        n_checks++;
        if (s_valid !== 1'b0) $display("FAIL fetch_drop_valid: cmd_valid=%b need 0", s_valid);
        else n_pass++;
    endtask

    task automatic test_store_short();
        int lp, fv, p0;
        fq = '{8'h80, 8'h00, 8'hCD, 8'hAB};
        p0 = pop_total;
        run_until_valid(20, lp, fv);
        n_checks++;
        if (fv < 0 || fv !== lp + 1 || pop_total - p0 !== 4)
            $display("FAIL store_short_timing: pops=%0d valid=%0d lastpop=%0d, need 4 pops and pop+1", pop_total - p0, fv, lp);
        else n_pass++;
        n_checks++;
        if (s_cmd !== CMD_STS) $display("FAIL store_short_fields: got %h need %h", s_cmd, CMD_STS);
        else n_pass++;
        accept();
    endtask

    task automatic test_store_ext();
        int lp, fv, p0;
        fq = '{8'h10, 8'h00, 8'h34, 8'h01, 8'hEF, 8'hBE};
        p0 = pop_total;
        run_until_valid(30, lp, fv);
        n_checks++;
        if (fv < 0 || s_cmd !== CMD_STX || pop_total - p0 !== 6)
            $display("FAIL store_ext: pops=%0d got %h need 6 pops and %h", pop_total - p0, s_cmd, CMD_STX);
        else n_pass++;
        accept();
    endtask

    task automatic test_backpressure();
        int lp, fv, xfers;
        logic [33:0] snap;
        fq = '{8'h09, 8'h01, 8'h0B, 8'h00};
        run_until_valid(20, lp, fv);
        snap  = s_cmd;
        xfers = 0;
        n_checks++;
        if (snap !== CMD_FETCH) $display("FAIL bp_first: got %h need %h", snap, CMD_FETCH);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_checks++;
            if (s_valid !== 1'b1 || s_re !== 1'b0 || s_cmd !== snap)
                $display("FAIL bp_hold: cyc %0d valid=%b re=%b cmd=%h need 1,0,%h", k, s_valid, s_re, s_cmd, snap);
            else n_pass++;
        end
        ready_drv = 1'b1;
        cycle();
        if (s_valid && s_rdy) xfers++;
        ready_drv = 1'b0;
        cycle();
        if (s_valid && s_rdy) xfers++;
        n_checks++;
        if (s_re !== 1'b1 || s_valid !== 1'b0) $display("FAIL bp_resume: re=%b valid=%b need 1,0", s_re, s_valid);
        else n_pass++;
        n_checks++;
        if (xfers !== 1) $display("FAIL bp_xfers: got %0d transfers need 1", xfers);
        else n_pass++;
        run_until_valid(20, lp, fv);
        n_checks++;
        if (s_cmd !== CMD_LOAD1) $display("FAIL bp_next: got %h need %h", s_cmd, CMD_LOAD1);
        else n_pass++;
        accept();
    endtask

    task automatic test_illegal_nop();
        int pop_cyc[8];
        int np, nerr, err_at, fv;
        np = 0; nerr = 0; err_at = -1; fv = -1;
        for (int k = 0; k < 8; k++) pop_cyc[k] = -100;
        fq = '{8'h07, 8'h00, 8'h05, 8'h00, 8'h03, 8'h00};
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (s_re && np < 8) begin
                pop_cyc[np] = s_cyc;
                np++;
            end
            if (s_err) begin
                nerr++;
                err_at = s_cyc;
            end
            if (s_valid) begin
                fv = s_cyc;
                break;
            end
        end
        n_checks++;
        if (nerr !== 1 || err_at !== pop_cyc[1] + 1)
            $display("FAIL illegal_err: pulses=%0d at %0d, need 1 pulse at %0d", nerr, err_at, pop_cyc[1] + 1);
        else n_pass++;
        n_checks++;
        if (np !== 6 || fv !== pop_cyc[5] + 1)
            $display("FAIL illegal_nop_valid: pops=%0d valid at %0d, need 6 pops and valid at %0d", np, fv, pop_cyc[5] + 1);
        else n_pass++;
        n_checks++;
        if (s_cmd !== CMD_LOAD0) $display("FAIL illegal_load: got %h need %h", s_cmd, CMD_LOAD0);
        else n_pass++;
        accept();
    endtask

    task automatic test_throughput();
        int t[4];
        int nt, c0;
        for (int k = 0; k < 4; k++) t[k] = 0;
        nt = 0;
        fq = '{8'h09, 8'h01, 8'h80, 8'h00, 8'hCD, 8'hAB,
               8'h10, 8'h00, 8'h34, 8'h01, 8'hEF, 8'hBE, 8'h09, 8'h01};
        ready_drv = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 40 && nt < 4; k++) begin
            cycle();
            if (s_valid && s_rdy) begin
                t[nt] = s_cyc;
                nt++;
            end
        end
        ready_drv = 1'b0;
        n_checks++;
        if (nt !== 4 || t[0] - c0 !== 2)
            $display("FAIL tput_first: transfers=%0d first at +%0d, need 4 and +2", nt, t[0] - c0);
        else n_pass++;
        n_checks++;
        if (t[1] - t[0] !== 5 || t[2] - t[1] !== 7 || t[3] - t[2] !== 3)
            $display("FAIL tput_gaps: gaps %0d,%0d,%0d need 5,7,3", t[1] - t[0], t[2] - t[1], t[3] - t[2]);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int early, lp, fv;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) fq = '{8'h01};
            else        fq = '{8'h10, 8'h00, 8'h34};
            for (int k = 0; k < 10 && fq.size() != 0; k++) cycle();
            early = 0;
            for (int k = 0; k < 16; k++) begin
                cycle();
                if (s_to || s_re) early++;
            end
            n_checks++;
            if (early !== 0) $display("FAIL timeout_early_%0d: %0d early events, need 0", c, early);
            else n_pass++;
            // Bytes land exactly on the timeout cycle and must not be popped.
            fq = '{8'h09, 8'h01};
            cycle();
            n_checks++;
            if (s_to !== 1'b1 || s_re !== 1'b0) $display("FAIL timeout_pulse_%0d: to=%b re=%b need 1,0", c, s_to, s_re);
            else n_pass++;
            cycle();
            n_checks++;
            if (s_to !== 1'b0 || s_re !== 1'b1) $display("FAIL timeout_after_%0d: to=%b re=%b need 0,1", c, s_to, s_re);
            else n_pass++;
            run_until_valid(20, lp, fv);
            n_checks++;
            if (fv < 0 || s_cmd !== CMD_FETCH) $display("FAIL timeout_recover_%0d: got %h need %h", c, s_cmd, CMD_FETCH);
            else n_pass++;
            accept();
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [7:0]  lo;
        logic [33:0] prev_cmd;
        bit          prev_hold, blk;
        int          run, n_err, n_to, viol, k;
        stim.delete();
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            if (op == 3'd4) op = 3'd1;
            lo = {5'($urandom), op};
            stim.push_back(lo);
            stim.push_back(8'($urandom));
            if (op == 3'd0) begin
                for (int b = 0; b < (lo[4] ? 4 : 2); b++) stim.push_back(8'($urandom));
            end
        end
        model_stream();
        fq = stim;
        got.delete();
        n_err = 0; n_to = 0; viol = 0; run = 0;
        prev_hold = 1'b0; prev_cmd = '0;
        for (k = 0; k < 6000; k++) begin
            blk = ($urandom_range(0, 99) < 30) && (run < 12);
            fifo_block = blk;
            run = blk ? run + 1 : 0;
            ready_drv = 1'($urandom_range(0, 1));
            cycle();
            if (prev_hold && (!s_valid || s_cmd !== prev_cmd)) viol++;
            if (s_valid && s_re) viol++;
            if (s_valid && s_rdy) got.push_back(s_cmd);
            if (s_err) n_err++;
            if (s_to) n_to++;
            prev_hold = s_valid && !s_rdy;
            prev_cmd  = s_cmd;
            if (fq.size() == 0 && got.size() == exp_q.size() && !s_valid) break;
        end
        fifo_block = 1'b0;
        ready_drv  = 1'b0;
        for (int j = 0; j < 4; j++) begin
            cycle();
            if (s_err) n_err++;
            if (s_to) n_to++;
        end
        n_checks++;
        if (got.size() !== exp_q.size()) $display("FAIL rand_count: got %0d cmds need %0d", got.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) $display("FAIL rand_cmd[%0d]: got %h need %h", i, got[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (n_err !== exp_err || n_to !== 0)
            $display("FAIL rand_flags: err=%0d to=%0d need err=%0d to=0", n_err, n_to, exp_err);
        else n_pass++;
        n_checks++;
        if (viol !== 0) $display("FAIL rand_protocol: %0d handshake violations need 0", viol);
        else n_pass++;
    endtask

    task automatic test_halt();
        int lp, fv;
        fq = '{8'h04, 8'h00, 8'h09, 8'h01};
        run_until_valid(20, lp, fv);
        n_checks++;
        if (fv < 0 || s_cmd !== CMD_HALT || s_halt !== 1'b0)
            $display("FAIL halt_issue: got %h halted=%b need %h halted=0", s_cmd, s_halt, CMD_HALT);
        else n_pass++;
        accept();
        for (int k = 0; k < 8; k++) begin
            cycle();
            n_checks++;
            if (s_halt !== 1'b1 || s_re !== 1'b0 || s_valid !== 1'b0)
                $display("FAIL halt_frozen: cyc %0d halted=%b re=%b valid=%b need 1,0,0", k, s_halt, s_re, s_valid);
            else n_pass++;
        end
        n_checks++;
        if (fq.size() !== 2) $display("FAIL halt_fifo: %0d bytes left need 2", fq.size());
        else n_pass++;
        do_reset();
        fq = '{8'h09, 8'h01};
        run_until_valid(20, lp, fv);
        n_checks++;
        if (fv < 0 || s_cmd !== CMD_FETCH || s_halt !== 1'b0)
            $display("FAIL halt_reset: got %h halted=%b need %h halted=0", s_cmd, s_halt, CMD_FETCH);
        else n_pass++;
        accept();
    endtask

    initial begin
        rst        = 1'b1;
        fifo_empty = 1'b1;
        fifo_rdata = 8'h00;
        cmd_ready  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_fetch();
        test_store_short();
        test_store_ext();
        test_backpressure();
        test_illegal_nop();
        test_throughput();
        test_timeout();
        test_random();
        test_halt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
